// File: rtl/flag_counter_prog.sv
// Run-time programmable terminal counter: one-shot or periodic runs, enable pauses the count,
// registered terminal tick, sticky done and a look-ahead near flag.
module flag_counter_prog #(
   parameter int NBITS     = 4,
   parameter int LOOKAHEAD = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             start,
   input  logic             enable,
   input  logic             mode,
   input  logic [NBITS-1:0] term_value,
   output logic [NBITS-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             tick,
   output logic             near
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [NBITS-1:0] ZERO = {NBITS{1'b0}};
   localparam logic [NBITS-1:0] ONE  = NBITS'(1);
   localparam logic [NBITS-1:0] LOOK = NBITS'(LOOKAHEAD);

   state_t           state_r, next_state_s;
   logic [NBITS-1:0] count_r, next_count_s;
   logic [NBITS-1:0] term_r, next_term_s;
   logic             mode_r, next_mode_s;
   logic             tick_r, next_tick_s;
   logic [NBITS-1:0] count_inc_s;

   // count stays below term_r while running, so this increment cannot wrap
   assign count_inc_s = count_r + ONE;

   // State and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
         count_r <= ZERO;
         term_r  <= ZERO;
         mode_r  <= 1'b0;
         tick_r  <= 1'b0;
      end else begin
         state_r <= next_state_s;
         count_r <= next_count_s;
         term_r  <= next_term_s;
         mode_r  <= next_mode_s;
         tick_r  <= next_tick_s;
      end
   end

   // Next-state and datapath update: clear beats start, start beats counting
   always_comb begin
      next_state_s = state_r;
      next_count_s = count_r;
      next_term_s  = term_r;
      next_mode_s  = mode_r;
      next_tick_s  = 1'b0;
      if (clear) begin
         next_state_s = IDLE;
         next_count_s = ZERO;
      end else if (start) begin
         next_term_s  = term_value;
         next_mode_s  = mode;
         next_count_s = ZERO;
         if (term_value == ZERO) begin
            next_state_s = DONE;
            next_tick_s  = 1'b1;
         end else begin
            next_state_s = RUN;
         end
      end else begin
         case (state_r)
            IDLE: begin
               next_count_s = ZERO;
            end
            RUN: begin
               if (enable) begin
                  if (count_inc_s == term_r) begin
                     next_tick_s = 1'b1;
                     if (mode_r) begin
                        next_count_s = ZERO;
                     end else begin
                        next_count_s = term_r;
                        next_state_s = DONE;
                     end
                  end else begin
                     next_count_s = count_inc_s;
                  end
               end else begin
                  next_count_s = count_r;
               end
            end
            DONE: begin
               next_count_s = term_r;
            end
            default: begin
               next_state_s = IDLE;
               next_count_s = ZERO;
            end
         endcase
      end
   end

   // Status decodes from the registered state and count
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      near = 1'b0;
      case (state_r)
         RUN:     busy = 1'b1;
         DONE:    done = 1'b1;
         default: begin
            busy = 1'b0;
            done = 1'b0;
         end
      endcase
      if ((state_r == RUN) && (term_r >= LOOK) && (count_r == (term_r - LOOK))) begin
         near = 1'b1;
      end else begin
         near = 1'b0;
      end
   end

   assign count = count_r;
   assign tick  = tick_r;

endmodule

// File: tb/tb_flag_counter_prog.sv
// Directed bench for flag_counter_prog: one task per scenario, hand-computed expectations.
module tb_flag_counter_prog;

   logic       clk = 1'b0;
   logic       reset;
   logic       clear;
   logic       start;
   logic       enable;
   logic       mode;
   logic [3:0] term_value;
   logic [3:0] count, count3;
   logic       busy, busy3, done, done3, tick, tick3, near, near3;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   flag_counter_prog #(.NBITS(4), .LOOKAHEAD(1)) dut (
      .clk(clk), .reset(reset), .clear(clear), .start(start), .enable(enable),
      .mode(mode), .term_value(term_value), .count(count), .busy(busy),
      .done(done), .tick(tick), .near(near)
   );

   flag_counter_prog #(.NBITS(4), .LOOKAHEAD(3)) dut3 (
      .clk(clk), .reset(reset), .clear(clear), .start(start), .enable(enable),
      .mode(mode), .term_value(term_value), .count(count3), .busy(busy3),
      .done(done3), .tick(tick3), .near(near3)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [3:0] tv, input logic md);
      start      = 1'b1;
      term_value = tv;
      mode       = md;
      step();
      start      = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; clear = 1'b0; start = 1'b0; enable = 1'b0; mode = 1'b0; term_value = 4'd0;
      step();
      step();
      n_checks++;
      if ({count, busy, done, tick, near} !== 8'h00) begin
         $display("FAIL reset_state: got %b expected 00000000", {count, busy, done, tick, near});
         n_fail++;
      end
      reset  = 1'b1;
      enable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         n_checks++;
         if ({count, busy, done, tick, near} !== 8'h00) begin
            $display("FAIL idle_hold[%0d]: got %b expected 00000000", i, {count, busy, done, tick, near});
            n_fail++;
         end
      end
   endtask

   task automatic test_one_shot();
      do_clear();
      enable = 1'b1;
      pulse_start(4'd8, 1'b0);
      for (int k = 0; k < 8; k++) begin
         n_checks++;
         if (count !== 4'(k) || busy !== 1'b1 || done !== 1'b0 || tick !== 1'b0 ||
             near !== (k == 7) || near3 !== (k == 5)) begin
            $display("FAIL oneshot_run[%0d]: got count=%0d busy=%b done=%b tick=%b near=%b near3=%b expected count=%0d busy=1 done=0 tick=0 near=%b near3=%b",
                     k, count, busy, done, tick, near, near3, k, (k == 7), (k == 5));
            n_fail++;
         end
         step();
      end
      n_checks++;
      if (count !== 4'd8 || tick !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || near !== 1'b0) begin
         $display("FAIL oneshot_term: got count=%0d tick=%b done=%b busy=%b near=%b expected 8 1 1 0 0",
                  count, tick, done, busy, near);
         n_fail++;
      end
      step();
      step();
      n_checks++;
      if (count !== 4'd8 || tick !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
         $display("FAIL oneshot_sticky: got count=%0d tick=%b done=%b busy=%b expected 8 0 1 0",
                  count, tick, done, busy);
         n_fail++;
      end
   endtask

   task automatic test_pause();
      int exp_count;
      do_clear();
      enable = 1'b1;
      pulse_start(4'd8, 1'b0);
      for (int e = 1; e <= 11; e++) begin
         enable = (e >= 5 && e <= 7) ? 1'b0 : 1'b1;
         step();
         exp_count = (e < 5) ? e : ((e <= 7) ? 4 : e - 3);
         n_checks++;
         if (count !== 4'(exp_count) || tick !== (e == 11) || done !== (e == 11)) begin
            $display("FAIL pause[%0d]: got count=%0d tick=%b done=%b expected count=%0d tick=%b done=%b",
                     e, count, tick, done, exp_count, (e == 11), (e == 11));
            n_fail++;
         end
      end
   endtask

   task automatic test_periodic();
      do_clear();
      enable = 1'b1;
      pulse_start(4'd5, 1'b1);
      for (int e = 1; e <= 20; e++) begin
         step();
         n_checks++;
         if (count !== 4'(e % 5) || tick !== (e % 5 == 0) || done !== 1'b0 || busy !== 1'b1 ||
             near !== (e % 5 == 4) || near3 !== (e % 5 == 2)) begin
            $display("FAIL periodic[%0d]: got count=%0d tick=%b done=%b busy=%b near=%b near3=%b expected count=%0d tick=%b done=0 busy=1 near=%b near3=%b",
                     e, count, tick, done, busy, near, near3, e % 5, (e % 5 == 0), (e % 5 == 4), (e % 5 == 2));
            n_fail++;
         end
      end
   endtask

   task automatic test_edge_terms();
      do_clear();
      enable = 1'b1;
      pulse_start(4'd0, 1'b0);
      n_checks++;
      if (count !== 4'd0 || done !== 1'b1 || tick !== 1'b1 || busy !== 1'b0 || near !== 1'b0) begin
         $display("FAIL zero_term: got count=%0d done=%b tick=%b busy=%b near=%b expected 0 1 1 0 0",
                  count, done, tick, busy, near);
         n_fail++;
      end
      step();
      n_checks++;
      if (count !== 4'd0 || done !== 1'b1 || tick !== 1'b0) begin
         $display("FAIL zero_term_after: got count=%0d done=%b tick=%b expected 0 1 0", count, done, tick);
         n_fail++;
      end
      pulse_start(4'd15, 1'b0);
      for (int e = 1; e <= 15; e++) begin
         step();
         n_checks++;
         if (count !== 4'(e) || tick !== (e == 15) || done !== (e == 15) || near !== (e == 14)) begin
            $display("FAIL max_term[%0d]: got count=%0d tick=%b done=%b near=%b expected count=%0d tick=%b done=%b near=%b",
                     e, count, tick, done, near, e, (e == 15), (e == 15), (e == 14));
            n_fail++;
         end
      end
      do_clear();
      pulse_start(4'd2, 1'b0);
      for (int e = 0; e < 3; e++) begin
         n_checks++;
         if (near3 !== 1'b0 || count3 !== 4'(e) || busy3 !== (e < 2) || done3 !== (e == 2) ||
             tick3 !== (e == 2) || near !== (e == 1)) begin
            $display("FAIL lookahead_gt_term[%0d]: got near3=%b count3=%0d busy3=%b done3=%b tick3=%b near=%b expected near3=0 count3=%0d busy3=%b done3=%b tick3=%b near=%b",
                     e, near3, count3, busy3, done3, tick3, near, e, (e < 2), (e == 2), (e == 2), (e == 1));
            n_fail++;
         end
         if (e < 2) step();
      end
   endtask

   task automatic test_collisions();
      do_clear();
      enable = 1'b1;
      pulse_start(4'd8, 1'b0);
      repeat (3) step();
      clear = 1'b1; start = 1'b1; term_value = 4'd5; mode = 1'b1;
      step();
      clear = 1'b0; start = 1'b0;
      n_checks++;
      if ({count, busy, done, tick} !== 7'h00) begin
         $display("FAIL start_clear: got %b expected 0000000", {count, busy, done, tick});
         n_fail++;
      end
      step();
      n_checks++;
      if ({count, busy, done, tick} !== 7'h00) begin
         $display("FAIL start_clear_idle: got %b expected 0000000", {count, busy, done, tick});
         n_fail++;
      end

      pulse_start(4'd8, 1'b0);
      repeat (6) step();
      pulse_start(4'd3, 1'b0);
      n_checks++;
      if (count !== 4'd0 || busy !== 1'b1 || tick !== 1'b0 || done !== 1'b0) begin
         $display("FAIL restart: got count=%0d busy=%b tick=%b done=%b expected 0 1 0 0", count, busy, tick, done);
         n_fail++;
      end
      step();
      step();
      n_checks++;
      if (count !== 4'd2 || tick !== 1'b0) begin
         $display("FAIL restart_count: got count=%0d tick=%b expected 2 0", count, tick);
         n_fail++;
      end
      step();
      n_checks++;
      if (count !== 4'd3 || tick !== 1'b1 || done !== 1'b1) begin
         $display("FAIL restart_newterm: got count=%0d tick=%b done=%b expected 3 1 1", count, tick, done);
         n_fail++;
      end

      pulse_start(4'd8, 1'b0);
      repeat (7) step();
      pulse_start(4'd8, 1'b0);
      n_checks++;
      if (count !== 4'd0 || tick !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
         $display("FAIL start_at_terminal: got count=%0d tick=%b busy=%b done=%b expected 0 0 1 0",
                  count, tick, busy, done);
         n_fail++;
      end

      repeat (3) step();
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if ({count, busy, done, tick, near} !== 8'h00 || {count3, busy3, done3, tick3, near3} !== 8'h00) begin
         $display("FAIL async_reset: got %b %b expected 00000000 00000000",
                  {count, busy, done, tick, near}, {count3, busy3, done3, tick3, near3});
         n_fail++;
      end
      step();
      reset = 1'b1;
      step();
      n_checks++;
      if ({count, busy, done, tick, near} !== 8'h00) begin
         $display("FAIL after_reset_idle: got %b expected 00000000", {count, busy, done, tick, near});
         n_fail++;
      end
   endtask

   initial begin
      test_reset();
      test_one_shot();
      test_pause();
      test_periodic();
      test_edge_terms();
      test_collisions();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
